qmult_seq: RTL and testbench
============================

// Module: qmult_seq
// PURPOSE
//  Sequential signed fixed-point multiplier; the inverse operator to the qdiv divider.
//  Uses the same Q-format and the same start/complete/overflow handshake, so datapath
//  FSMs can drive either unit interchangeably.
//  Radix-2 shift-add on magnitudes, then sign restore and saturation.
//  Result is truncated toward zero.
// PARAMETERS
//  N  16  total word width, two's complement, sign bit included
//  Q  8   fractional bits (N=16, Q=8 gives Q8.8)
// PORTS
//  i_clk           in   1  clock; all state changes on the rising edge
//  i_rst_n         in   1  asynchronous, active-low reset
//  i_start         in   1  start request; sampled only while idle
//  i_multiplicand  in   N  signed operand A, captured when start is accepted
//  i_multiplier    in   N  signed operand B, captured when start is accepted
//  o_product_out   out  N  signed product; held stable until the next completion
//  o_complete      out  1  one-cycle pulse when o_product_out/o_overflow become valid
//  o_overflow      out  1  true product out of range, so the result was saturated
//  o_busy          out  1  high from start acceptance until the completion edge
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FSM=IDLE; o_product_out=0, o_complete=0, o_overflow=0, o_busy=0
//   - accumulator and counter cleared
//   - reset during an operation aborts it; no o_complete is ever produced for it
//  Reset release: first rising edge with i_rst_n=1 behaves as IDLE.
//  FSM states: IDLE -> MUL -> NORM -> IDLE.
//  IDLE:
//   - on edge with i_start=1: latch |A|, |B| as N-bit unsigned; sign = A[N-1]^B[N-1]
//   - also: acc(2N bits)=0, cnt=0, o_overflow=0, o_busy=1, go to MUL
//   - |−2^(N−1)| = 2^(N−1) must be representable (unsigned magnitude, no wrap)
//  MUL: one multiplier bit per cycle, LSB first.
//   - if |B|[cnt]=1: acc += |A| << cnt
//   - cnt++; after N iterations (cnt==N-1 processed) go to NORM
//  NORM (single cycle):
//   - m = acc >> Q (truncate magnitude)
//   - positive result: overflow if m > 2^(N-1)-1; saturate to 0111..1
//   - negative result: overflow if m > 2^(N-1); saturate to 100..0
//   - otherwise product = sign ? -m : m
//   - register o_product_out and o_overflow; o_complete=1 for this cycle only
//   - o_busy=0; go to IDLE
//  Latency: start sampled at edge E0; o_complete is high in the cycle after edge
//   E0+N+1 (17 cycles for N=16). Latency is fixed and independent of operand values.
//  i_start while busy: ignored; no queueing, no effect on the running operation.
//  i_start in the o_complete cycle: FSM is already IDLE, so it is accepted. This
//   gives back-to-back throughput of one result per N+2 cycles.
//  Zero operand or result truncated to 0: output is 0x0000 regardless of sign;
//   o_overflow=0.
//  o_overflow holds its value after completion; it is cleared only on start acceptance.
// STRUCTURE
//  Shared package qmath_pkg:
//   - state enum typedef (IDLE/MUL/NORM)
//   - default N/Q localparams, shared with qdiv
//   - function returning saturation max/min for a given N
//  No sub-module; a single always_ff FSM plus a small combinational NORM stage.
// TESTING (Q8.8, N=16; check o_complete exactly 17 cycles after start)
//  1 A=0x0300 (3.0), B=0x0080 (0.5) -> 0x0180 (1.5), ovf=0
//  2 A=0xFD00 (-3.0), B=0x0080 -> 0xFE80 (-1.5), ovf=0; swapped operands give same
//  3 A=0x1000 (16), B=0x1000 -> 0x7FFF, ovf=1
//    A=0xF000, B=0x1000 -> 0x8000, ovf=1
//  4 A=0x8000 (-128), B=0x0100 (1.0) -> 0x8000, ovf=0
//    A=0xFFFF, B=0x0080 -> 0x0000, ovf=0 (truncation toward zero)
//  5 start test 1; pulse i_rst_n low at cycle 8 -> no o_complete, outputs 0;
//    restart -> 0x0180
//  6 hold i_start=1 continuously with new operands each completion -> completions
//    every 18 cycles; starts during busy ignored

Source files
------------

// File: rtl/qmath_pkg.sv
// Shared definitions for the sequential Q-format arithmetic units (qmult_seq, qdiv).
// Default word/fraction widths, FSM state encoding and saturation helpers.
package qmath_pkg;

  localparam int unsigned QN = 16;
  localparam int unsigned QQ = 8;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StNorm
  } state_e;

  // Largest positive two's complement value for an n-bit word (0111..1).
  function automatic logic [63:0] sat_max(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Most negative value (100..0); also the magnitude 2^(n-1) when read unsigned.
  function automatic logic [63:0] sat_min(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/qmult_seq.sv
// Sequential signed fixed-point multiplier: radix-2 shift-add on magnitudes,
// then sign restore, truncation toward zero and saturation.
module qmult_seq
  import qmath_pkg::*;
#(
  parameter int unsigned N = QN,
  parameter int unsigned Q = QQ
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_product_out,
  output logic         o_complete,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MW   = 2 * N - Q;

  localparam logic [N-1:0]  SatMax    = N'(sat_max(N));
  localparam logic [N-1:0]  SatMin    = N'(sat_min(N));
  localparam logic [MW-1:0] MaxPosMag = MW'(sat_max(N));
  localparam logic [MW-1:0] MaxNegMag = MW'(sat_min(N));
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    a_mag_q, a_mag_d;
  logic [N-1:0]    b_mag_q, b_mag_d;
  logic            sign_q, sign_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    prod_q, prod_d;
  logic            ovf_q, ovf_d;
  logic            cmp_q, cmp_d;
  logic            busy_q, busy_d;

  logic [N-1:0]  a_abs, b_abs;
  logic [MW-1:0] mag;
  logic [N-1:0]  norm_prod;
  logic          norm_ovf;

  // Magnitudes are unsigned N-bit, so |-2^(N-1)| = 2^(N-1) does not wrap.
  always_comb begin
    a_abs = i_multiplicand[N-1] ? (~i_multiplicand + 1'b1) : i_multiplicand;
    b_abs = i_multiplier[N-1]   ? (~i_multiplier + 1'b1)   : i_multiplier;
  end

  assign mag = acc_q[2*N-1:Q];

  always_comb begin
    norm_ovf  = 1'b0;
    norm_prod = mag[N-1:0];
    if (sign_q) begin
      if (mag > MaxNegMag) begin
        norm_ovf  = 1'b1;
        norm_prod = SatMin;
      end else begin
        // A zero magnitude negates to zero, so -0 never appears.
        norm_prod = ~mag[N-1:0] + 1'b1;
      end
    end else if (mag > MaxPosMag) begin
      norm_ovf  = 1'b1;
      norm_prod = SatMax;
    end
  end

  always_comb begin
    state_d = state_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    cmp_d   = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          sign_d  = i_multiplicand[N-1] ^ i_multiplier[N-1];
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StMul;
        end
      end
      StMul: begin
        if (b_mag_q[cnt_q]) begin
          acc_d = acc_q + ({{N{1'b0}}, a_mag_q} << cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        prod_d  = norm_prod;
        ovf_d   = norm_ovf;
        cmp_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      a_mag_q <= '0;
      b_mag_q <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
      cmp_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
      cmp_q   <= cmp_d;
      busy_q  <= busy_d;
    end
  end

  assign o_product_out = prod_q;
  assign o_overflow    = ovf_q;
  assign o_complete    = cmp_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_qmult_seq.sv
// Scoreboard bench for qmult_seq (Q8.8): stimulus pushes expected results,
// a negedge monitor pops and checks value, overflow and 17-cycle latency.
module tb_qmult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic [15:0] prod;
  logic        cmp, ovf, busy;

  qmult_seq #(
    .N(16),
    .Q(8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_multiplicand(a),
    .i_multiplier  (b),
    .o_product_out (prod),
    .o_complete    (cmp),
    .o_overflow    (ovf),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          start_e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_cmp  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cmp === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          check("unexpected_complete", {31'b0, cmp}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("product", {16'b0, prod}, {16'b0, e.prod});
          check("overflow", {31'b0, ovf}, {31'b0, e.ovf});
          check("busy_in_complete", {31'b0, busy}, 32'd0);
          check("latency", 32'(cyc - e.start_e), 32'd17);
        end
      end
    end
  end

  // Call at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic [15:0] p, input logic o);
    exp_t e;
    a = ta;
    b = tb_v;
    start = 1'b1;
    e.prod = p;
    e.ovf = o;
    e.start_e = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic wait_cmp(output int at);
    at = -1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmp === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  logic [15:0] t6_a[5] = '{16'h0300, 16'hFD00, 16'h1000, 16'h0200, 16'h8000};
  logic [15:0] t6_b[5] = '{16'h0080, 16'h0080, 16'h1000, 16'h0200, 16'h0100};
  logic [15:0] t6_p[5] = '{16'h0180, 16'hFE80, 16'h7FFF, 16'h0400, 16'h8000};
  logic        t6_o[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int n0, prev, at;
    exp_t e;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_product", {16'b0, prod}, 32'd0);
    check("rst_complete", {31'b0, cmp}, 32'd0);
    check("rst_overflow", {31'b0, ovf}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1, with a start during busy that must be ignored.
    issue(16'h0300, 16'h0080, 16'h0180, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_running", {31'b0, busy}, 32'd1);
    a = 16'h1000;
    b = 16'h1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check("held_product", {16'b0, prod}, 32'h0180);
    check("held_idle_busy", {31'b0, busy}, 32'd0);

    // Test 2 and swapped operands.
    issue(16'hFD00, 16'h0080, 16'hFE80, 1'b0);
    drain();
    issue(16'h0080, 16'hFD00, 16'hFE80, 1'b0);
    drain();

    // Test 4: most negative exact, truncation toward zero.
    issue(16'h8000, 16'h0100, 16'h8000, 1'b0);
    drain();
    issue(16'hFFFF, 16'h0080, 16'h0000, 1'b0);
    drain();

    // Test 3: saturation both ways; overflow must persist after completion.
    issue(16'h1000, 16'h1000, 16'h7FFF, 1'b1);
    drain();
    issue(16'hF000, 16'h1000, 16'h8000, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("held_overflow", {31'b0, ovf}, 32'd1);

    // Test 5: reset mid-operation aborts it with no completion.
    a = 16'h0300;
    b = 16'h0080;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_product", {16'b0, prod}, 32'd0);
    check("abort_overflow", {31'b0, ovf}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_cmp;
    repeat (25) @(negedge clk);
    check("abort_no_complete", 32'(n_cmp - n0), 32'd0);
    issue(16'h0300, 16'h0080, 16'h0180, 1'b0);
    drain();

    // Test 6: start held high, new operands each completion -> 18-cycle period.
    a = t6_a[0];
    b = t6_b[0];
    start = 1'b1;
    e.prod = t6_p[0];
    e.ovf = t6_o[0];
    e.start_e = cyc + 1;
    sb.push_back(e);
    prev = 0;
    for (int k = 1; k < 5; k++) begin
      wait_cmp(at);
      if (k > 1) check("b2b_period", 32'(at - prev), 32'd18);
      prev = at;
      a = t6_a[k];
      b = t6_b[k];
      e.prod = t6_p[k];
      e.ovf = t6_o[k];
      e.start_e = cyc + 1;
      sb.push_back(e);
    end
    wait_cmp(at);
    check("b2b_period", 32'(at - prev), 32'd18);
    start = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
